ex_mem_reg: RTL and testbench
=============================

// Module: ex_mem_reg
// PURPOSE
//  EX/MEM pipeline register. Sits directly downstream of the EX stage and feeds MEM.
//  It captures EX results: GPR write, HI/LO write and a valid bit.
//  It applies the global stall/flush rules and inserts bubbles.
//  It also holds multi-cycle accumulate state (MADD/MSUB partial product + step count) that is fed back to EX.
// PARAMETERS
//  DW   32  GPR / HI / LO data width (`RegBus)
//  AW    5  GPR address width (`RegAddrBus)
//  CW    2  accumulate step-counter width
// PORTS
//  clk           in   1     rising-edge clock
//  rst           in   1     reset, synchronous, active-high
//  flush         in   1     kill the in-flight instruction (exception/branch squash)
//  ex_stall      in   1     EX stage held this cycle
//  mem_stall     in   1     MEM stage held this cycle
//  ex_valid      in   1     EX holds a real instruction
//  ex_we         in   1     EX GPR write enable
//  ex_waddr      in   AW    EX GPR write address
//  ex_wdata      in   DW    EX GPR write data
//  ex_hilo_we    in   1     EX HI/LO write enable
//  ex_hi         in   DW    EX HI value
//  ex_lo         in   DW    EX LO value
//  acc_temp_i    in   2*DW  EX partial accumulate product
//  acc_cnt_i     in   CW    EX accumulate step number
//  mem_valid     out  1     MEM holds a real instruction
//  mem_we        out  1     MEM GPR write enable
//  mem_waddr     out  AW    MEM GPR write address
//  mem_wdata     out  DW    MEM GPR write data
//  mem_hilo_we   out  1     MEM HI/LO write enable (also drives EX HI/LO forwarding)
//  mem_hi        out  DW    MEM HI value
//  mem_lo        out  DW    MEM LO value
//  acc_temp_o    out  2*DW  held partial product, back to EX
//  acc_cnt_o     out  CW    held step count, back to EX
// BEHAVIOUR
//  - Every output updates only on the rising clk edge; no combinational path from in to out.
//  - Reset (rst=1 at edge): all outputs are 0. rst has priority over flush and over stalls.
//  - Pipeline-field priority per edge (rst > flush > stall > load):
//    * flush=1: load a bubble. All mem_* outputs go to 0, including mem_valid, mem_we and mem_hilo_we.
//    * ex_stall=1, mem_stall=0: load a bubble. EX result is not consumed; MEM gets a NOP.
//    * ex_stall=1, mem_stall=1: hold all mem_* outputs unchanged.
//    * ex_stall=0, mem_stall=1: illegal combination. Hold all mem_* outputs, same as the both-stalled case.
//    * ex_stall=0, mem_stall=0: load all ex_* values; mem_valid <= ex_valid.
//  - Bubble rule: mem_we and mem_hilo_we are forced to 0 whenever mem_valid is 0 at the output.
//  - Latency: 1 cycle, EX to MEM.
//  - Accumulate state (acc_temp_o, acc_cnt_o):
//    * States: IDLE (cnt_o=0) and STEP (cnt_o!=0).
//    * ex_stall=1 and flush=0: acc_temp_o <= acc_temp_i, acc_cnt_o <= acc_cnt_i (EX parks its first-cycle product).
//    * otherwise: acc_temp_o <= 0, acc_cnt_o <= 0, i.e. back to IDLE.
//    * flush mid-accumulate: state is cleared the same edge; the next EX start sees cnt=0.
//    * rst mid-accumulate: state is cleared the same edge.
//    * acc_cnt_i is never incremented here; the value is held verbatim. No wrap handling is needed.
//  - mem_hilo_we/mem_hi/mem_lo are the MEM-stage HI/LO forwarding source for EX. They must equal the registered values, never the ex_* inputs.
// CONFIGURATION
//  - Macro EX_MEM_ACC_EN:
//    * Defined: accumulate state registers are present and behave as above.
//    * Undefined: acc_temp_o and acc_cnt_o are tied to 0 with no flops; acc_temp_i and acc_cnt_i are ignored.
//      The pipeline fields behave identically in both builds.
// TESTING
//  1. rst=1 for 2 cycles with all inputs at 1 -> every output is 0. Release -> outputs still 0 until the first load.
//  2. Normal load: ex_valid=1, we=1, waddr=5'd3, wdata=32'h1234_5678, no stall -> next edge mem_* carry these values, mem_valid=1.
//  3. ex_stall=1, mem_stall=0 with a valid EX result -> next edge mem_valid=0, mem_we=0, mem_hilo_we=0.
//     Then ex_stall=mem_stall=1 for 3 cycles -> outputs unchanged throughout.
//  4. flush=1 together with ex_stall=1 and acc_cnt_i=1, acc_temp_i=64'hFFFF_0000_0000_0001 -> next edge mem_* = 0 and acc_cnt_o=0.
//  5. MADD, macro defined: cycle 0 ex_stall=1, acc_cnt_i=1, acc_temp_i=64'h0000_0002_0000_0003 -> acc_* outputs show these values.
//     Cycle 1 ex_stall=0 -> acc_cnt_o=0, acc_temp_o=0, and the final HI/LO from EX is loaded into mem_hi/mem_lo with mem_hilo_we=1.
//  6. Macro undefined, rerun scenario 5 -> acc_cnt_o and acc_temp_o stay 0 every cycle; mem_* match the scenario 5 results.

Source files
------------

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: captures EX results, applies stall/flush/bubble rules,
// and parks the multi-cycle MADD/MSUB accumulate state (enabled by EX_MEM_ACC_EN).
module ex_mem_reg #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5,
    parameter int unsigned CW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            ex_stall,
    input  logic            mem_stall,
    input  logic            ex_valid,
    input  logic            ex_we,
    input  logic [AW-1:0]   ex_waddr,
    input  logic [DW-1:0]   ex_wdata,
    input  logic            ex_hilo_we,
    input  logic [DW-1:0]   ex_hi,
    input  logic [DW-1:0]   ex_lo,
    input  logic [2*DW-1:0] acc_temp_i,
    input  logic [CW-1:0]   acc_cnt_i,
    output logic            mem_valid,
    output logic            mem_we,
    output logic [AW-1:0]   mem_waddr,
    output logic [DW-1:0]   mem_wdata,
    output logic            mem_hilo_we,
    output logic [DW-1:0]   mem_hi,
    output logic [DW-1:0]   mem_lo,
    output logic [2*DW-1:0] acc_temp_o,
    output logic [CW-1:0]   acc_cnt_o
);

    logic            nxt_valid;
    logic            nxt_we;
    logic [AW-1:0]   nxt_waddr;
    logic [DW-1:0]   nxt_wdata;
    logic            nxt_hilo_we;
    logic [DW-1:0]   nxt_hi;
    logic [DW-1:0]   nxt_lo;

    // Next pipeline contents: hold by default, bubble on flush or EX-only stall, load when free.
    always_comb begin
        nxt_valid   = mem_valid;
        nxt_we      = mem_we;
        nxt_waddr   = mem_waddr;
        nxt_wdata   = mem_wdata;
        nxt_hilo_we = mem_hilo_we;
        nxt_hi      = mem_hi;
        nxt_lo      = mem_lo;
        if (flush || (ex_stall && !mem_stall)) begin
            nxt_valid   = 1'b0;
            nxt_we      = 1'b0;
            nxt_waddr   = '0;
            nxt_wdata   = '0;
            nxt_hilo_we = 1'b0;
            nxt_hi      = '0;
            nxt_lo      = '0;
        end else if (!ex_stall && !mem_stall) begin
            // Write enables are gated so an invalid slot can never commit.
            nxt_valid   = ex_valid;
            nxt_we      = ex_valid & ex_we;
            nxt_waddr   = ex_waddr;
            nxt_wdata   = ex_wdata;
            nxt_hilo_we = ex_valid & ex_hilo_we;
            nxt_hi      = ex_hi;
            nxt_lo      = ex_lo;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_valid   <= 1'b0;
            mem_we      <= 1'b0;
            mem_waddr   <= '0;
            mem_wdata   <= '0;
            mem_hilo_we <= 1'b0;
            mem_hi      <= '0;
            mem_lo      <= '0;
        end else begin
            mem_valid   <= nxt_valid;
            mem_we      <= nxt_we;
            mem_waddr   <= nxt_waddr;
            mem_wdata   <= nxt_wdata;
            mem_hilo_we <= nxt_hilo_we;
            mem_hi      <= nxt_hi;
            mem_lo      <= nxt_lo;
        end
    end

`ifdef EX_MEM_ACC_EN
    // EX parks its partial product only while it is itself stalled; anything else returns to IDLE.
    always_ff @(posedge clk) begin
        if (rst || flush || !ex_stall) begin
            acc_temp_o <= '0;
            acc_cnt_o  <= '0;
        end else begin
            acc_temp_o <= acc_temp_i;
            acc_cnt_o  <= acc_cnt_i;
        end
    end
`else
    logic unused_acc;
    assign unused_acc = ^{acc_temp_i, acc_cnt_i};
    assign acc_temp_o = '0;
    assign acc_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Scoreboard bench for ex_mem_reg: directed vectors push expected MEM contents,
// a monitor pops and checks one entry after every clock edge.
module tb_ex_mem_reg;

    typedef struct {
        logic        v;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        hwe;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [63:0] at;
        logic [1:0]  ac;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, flush, ex_stall, mem_stall;
    logic        ex_valid, ex_we, ex_hilo_we;
    logic [4:0]  ex_waddr;
    logic [31:0] ex_wdata, ex_hi, ex_lo;
    logic [63:0] acc_temp_i;
    logic [1:0]  acc_cnt_i;
    logic        mem_valid, mem_we, mem_hilo_we;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata, mem_hi, mem_lo;
    logic [63:0] acc_temp_o;
    logic [1:0]  acc_cnt_o;

    exp_t exp_q[$];
    int   tests  = 0;
    int   failed = 0;
    int   cyc    = 0;

    ex_mem_reg #(.DW(32), .AW(5), .CW(2)) dut (
        .clk(clk), .rst(rst), .flush(flush), .ex_stall(ex_stall), .mem_stall(mem_stall),
        .ex_valid(ex_valid), .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
        .ex_hilo_we(ex_hilo_we), .ex_hi(ex_hi), .ex_lo(ex_lo),
        .acc_temp_i(acc_temp_i), .acc_cnt_i(acc_cnt_i),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_hilo_we(mem_hilo_we), .mem_hi(mem_hi), .mem_lo(mem_lo),
        .acc_temp_o(acc_temp_o), .acc_cnt_o(acc_cnt_o)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
        tests++;
        if (act !== req) begin
            failed++;
            $display("FAIL cycle %0d %s: got %h expected %h", cyc, name, act, req);
        end
    endfunction

    // Monitor: every edge the register presents new contents; compare against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("mem_valid",   64'(mem_valid),   64'(e.v));
                chk("mem_we",      64'(mem_we),      64'(e.we));
                chk("mem_waddr",   64'(mem_waddr),   64'(e.wa));
                chk("mem_wdata",   64'(mem_wdata),   64'(e.wd));
                chk("mem_hilo_we", 64'(mem_hilo_we), 64'(e.hwe));
                chk("mem_hi",      64'(mem_hi),      64'(e.hi));
                chk("mem_lo",      64'(mem_lo),      64'(e.lo));
                chk("acc_temp_o",  acc_temp_o,       e.at);
                chk("acc_cnt_o",   64'(acc_cnt_o),   64'(e.ac));
            end
        end
    end

    // Drive one cycle of inputs on the falling edge and queue the contents expected after the next rising edge.
    task automatic step(
        input logic r, input logic f, input logic es, input logic ms,
        input logic v, input logic we, input logic [4:0] wa, input logic [31:0] wd,
        input logic hwe, input logic [31:0] hi, input logic [31:0] lo,
        input logic [63:0] at, input logic [1:0] ac,
        input logic ev, input logic ewe, input logic [4:0] ewa, input logic [31:0] ewd,
        input logic ehwe, input logic [31:0] ehi, input logic [31:0] elo,
        input logic [63:0] eat, input logic [1:0] eac);
        exp_t e;
        @(negedge clk);
        rst = r; flush = f; ex_stall = es; mem_stall = ms;
        ex_valid = v; ex_we = we; ex_waddr = wa; ex_wdata = wd;
        ex_hilo_we = hwe; ex_hi = hi; ex_lo = lo;
        acc_temp_i = at; acc_cnt_i = ac;
        e.v = ev; e.we = ewe; e.wa = ewa; e.wd = ewd; e.hwe = ehwe; e.hi = ehi; e.lo = elo;
`ifdef EX_MEM_ACC_EN
        e.at = eat; e.ac = eac;
`else
        e.at = 64'h0; e.ac = 2'h0;
        if (eat != 64'h0 || eac != 2'h0) e.at = 64'h0;
`endif
        exp_q.push_back(e);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; ex_stall = 1'b0; mem_stall = 1'b0;
        ex_valid = 1'b0; ex_we = 1'b0; ex_waddr = '0; ex_wdata = '0;
        ex_hilo_we = 1'b0; ex_hi = '0; ex_lo = '0; acc_temp_i = '0; acc_cnt_i = '0;

        // Reset with every input high, then release with an idle EX
        repeat (2) step(1,1,1,1, 1,1,5'h1f,32'hFFFF_FFFF,1,32'hFFFF_FFFF,32'hFFFF_FFFF,64'hFFFF_FFFF_FFFF_FFFF,2'h3,
                        0,0,5'h0,32'h0,0,32'h0,32'h0,64'h0,2'h0);
        step(0,0,0,0, 0,0,5'h0,32'h0,0,32'h0,32'h0,64'h0,2'h0,
             0,0,5'h0,32'h0,0,32'h0,32'h0,64'h0,2'h0);
        // Normal load
        step(0,0,0,0, 1,1,5'd3,32'h1234_5678,0,32'hAAAA_0001,32'hBBBB_0002,64'h0,2'h0,
             1,1,5'd3,32'h1234_5678,0,32'hAAAA_0001,32'hBBBB_0002,64'h0,2'h0);
        // EX-only stall inserts a bubble
        step(0,0,1,0, 1,1,5'd7,32'hDEAD_BEEF,1,32'h1,32'h2,64'h0,2'h0,
             0,0,5'h0,32'h0,0,32'h0,32'h0,64'h0,2'h0);
        // Both stalled: hold the bubble, EX parks accumulate state
        repeat (3) step(0,0,1,1, 1,1,5'd9,32'hCAFE_F00D,1,32'h5,32'h6,64'h1111_2222_3333_4444,2'h2,
                        0,0,5'h0,32'h0,0,32'h0,32'h0,64'h1111_2222_3333_4444,2'h2);
        // Load a live HI/LO + GPR result
        step(0,0,0,0, 1,1,5'd12,32'h0000_00A5,1,32'h0000_00C1,32'h0000_00C2,64'h0,2'h0,
             1,1,5'd12,32'h0000_00A5,1,32'h0000_00C1,32'h0000_00C2,64'h0,2'h0);
        // MEM-only stall (illegal) holds; accumulate returns to IDLE
        repeat (2) step(0,0,0,1, 1,0,5'd1,32'h1,0,32'h3,32'h4,64'h5,2'h1,
                        1,1,5'd12,32'h0000_00A5,1,32'h0000_00C1,32'h0000_00C2,64'h0,2'h0);
        // Both stalled with live contents: hold, accumulate parks
        step(0,0,1,1, 1,0,5'd2,32'h2,0,32'h3,32'h4,64'h77,2'h3,
             1,1,5'd12,32'h0000_00A5,1,32'h0000_00C1,32'h0000_00C2,64'h77,2'h3);
        // Flush beats stall and clears accumulate state
        step(0,1,1,0, 1,1,5'd4,32'h4444,1,32'h5,32'h6,64'hFFFF_0000_0000_0001,2'h1,
             0,0,5'h0,32'h0,0,32'h0,32'h0,64'h0,2'h0);
        // Invalid EX slot: write enables must not propagate
        step(0,0,0,0, 0,1,5'd6,32'h0000_0066,1,32'h7,32'h8,64'h0,2'h0,
             0,0,5'd6,32'h0000_0066,0,32'h7,32'h8,64'h0,2'h0);
        // MADD: first cycle parks product, second cycle loads final HI/LO
        step(0,0,1,0, 1,0,5'd0,32'h0,1,32'h0,32'h0,64'h0000_0002_0000_0003,2'h1,
             0,0,5'h0,32'h0,0,32'h0,32'h0,64'h0000_0002_0000_0003,2'h1);
        step(0,0,0,0, 1,0,5'd0,32'h0,1,32'h0000_0002,32'h0000_0009,64'h0,2'h0,
             1,0,5'd0,32'h0,1,32'h0000_0002,32'h0000_0009,64'h0,2'h0);
        // Park accumulate state, then reset mid-accumulate
        step(0,0,1,1, 1,1,5'd8,32'h8,1,32'h8,32'h8,64'hABCD,2'h2,
             1,0,5'd0,32'h0,1,32'h0000_0002,32'h0000_0009,64'hABCD,2'h2);
        step(1,0,1,1, 1,1,5'd8,32'h8,1,32'h8,32'h8,64'hABCD,2'h2,
             0,0,5'h0,32'h0,0,32'h0,32'h0,64'h0,2'h0);

        repeat (3) @(posedge clk);
        #2;
        tests++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
